dmem_arbiter: RTL

- Shares the single-port data memory between two requesters: port 0 is the MIPS core data port, and port 1 is an auxiliary master (program loader / debug / DMA).
- Sits between the core, the aux master and data_memory in the top level.
- Performs one memory access per granted cycle and returns an ack with registered read data one cycle later.
- Core has fixed priority, with a starvation guard that forces an aux grant after MAX_WAIT lost cycles.

---
 rtl/dmem_arb_pkg.sv | 10 +
 rtl/dmem_arb_wait_ctr.sv | 18 +
 rtl/dmem_arbiter.sv | 78 +++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, GNT_CORE, GNT_AUX} state_t;
  localparam int PORT_CORE = 0;
  localparam int PORT_AUX = 1;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int MAX_WAIT_DEF = 4;
  localparam int CNT_W = 8;
endpackage

// File: rtl/dmem_arb_wait_ctr.sv
// dmem_arb_wait_ctr: saturating count of cycles the aux port was refused.
module dmem_arb_wait_ctr
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);
  assign sat = cnt == CNT_W'(MAX_WAIT);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc && !sat) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the core and an aux master;
// core has priority, aux is forced through after MAX_WAIT refusals.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_ack,
  output logic [DATA_W-1:0] aux_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_t state, state_nx;
  logic [1:0] gnt;
  logic [CNT_W-1:0] wait_cnt;
  logic force_aux, core_elig, aux_elig;
  logic [DATA_W-1:0] core_q, aux_q;

  dmem_arb_wait_ctr #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk(clk),
    .rst(rst),
    .clr(gnt[PORT_AUX]),
    .inc(aux_elig && !gnt[PORT_AUX]),
    .cnt(wait_cnt),
    .sat(force_aux)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      core_q <= '0;
      aux_q  <= '0;
    end else begin
      state <= state_nx;
      if (gnt[PORT_CORE] && !core_we) core_q <= mem_rdata;
      if (gnt[PORT_AUX] && !aux_we) aux_q <= mem_rdata;
    end
  end

  // a port whose ack is up still presents the finished request, so it sits out
  always_comb begin
    core_elig      = core_req && !core_ack;
    aux_elig       = aux_req && !aux_ack;
    gnt[PORT_AUX]  = !rst && aux_elig && (force_aux || !core_elig);
    gnt[PORT_CORE] = !rst && core_elig && !gnt[PORT_AUX];
    state_nx       = gnt[PORT_AUX] ? GNT_AUX : gnt[PORT_CORE] ? GNT_CORE : IDLE;
  end

  always_comb begin
    core_ack   = !rst && state == GNT_CORE;
    aux_ack    = !rst && state == GNT_AUX;
    core_rdata = rst ? '0 : core_q;
    aux_rdata  = rst ? '0 : aux_q;
    core_stall = core_req && !core_ack;
    mem_addr   = gnt[PORT_AUX] ? aux_addr : gnt[PORT_CORE] ? core_addr : '0;
    mem_wdata  = gnt[PORT_AUX] ? aux_wdata : gnt[PORT_CORE] ? core_wdata : '0;
    mem_write  = gnt[PORT_AUX] ? aux_we : gnt[PORT_CORE] && core_we;
    mem_read   = gnt[PORT_AUX] ? !aux_we : gnt[PORT_CORE] && !core_we;
  end
endmodule
